// File: rtl/plab5_mcore_mem_tdm_arb_if.sv
// Valid/ready memory message channel used for the arbiter's request, response and memory ports.
// The producer of a message takes the master modport and the consumer takes the slave modport.
interface plab5_mcore_mem_tdm_arb_if #(
    parameter int p_ctrl_nbits = 47,
    parameter int p_data_nbits = 128
);
    logic                    val;
    logic                    rdy;
    logic [p_ctrl_nbits-1:0] control;
    logic [p_data_nbits-1:0] data;

    modport master (output val, output control, output data, input rdy);
    modport slave  (input val, input control, input data, output rdy);
endinterface

// File: rtl/plab5_mcore_mem_tdm_arb.sv
// Time-division arbiter sharing one single-ported memory between two security domains.
// Grant timing follows a free-running slot schedule only; responses return via per-domain buffers.
module plab5_mcore_mem_tdm_arb #(
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_data_nbits   = 128,
    parameter int p_req_cnbits   = 47,
    parameter int p_resp_cnbits  = 15,
    parameter int p_slot_cycles  = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    plab5_mcore_mem_tdm_arb_if.slave          req0,
    plab5_mcore_mem_tdm_arb_if.slave          req1,
    plab5_mcore_mem_tdm_arb_if.master         resp0,
    plab5_mcore_mem_tdm_arb_if.master         resp1,
    plab5_mcore_mem_tdm_arb_if.master         mem_req,
    output logic                              mem_req_domain,
    plab5_mcore_mem_tdm_arb_if.slave          mem_resp,
    output logic                              slot_owner,
    output logic                              overrun
);

    if (p_slot_cycles < 2) begin : g_bad_slot_cycles
        $error("p_slot_cycles must be at least 2");
    end
    if (p_req_cnbits <= p_opaque_nbits + p_addr_nbits) begin : g_bad_req_cnbits
        $error("p_req_cnbits too narrow for opaque and address fields");
    end

    localparam int c_cnt_nbits = $clog2(p_slot_cycles);
    localparam logic [c_cnt_nbits-1:0] c_cnt_last = c_cnt_nbits'(p_slot_cycles - 1);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [c_cnt_nbits-1:0]   cnt;
    logic                     pend_dom;
    logic [1:0]               full;
    logic [p_resp_cnbits-1:0] buf_ctl  [2];
    logic [p_data_nbits-1:0]  buf_data [2];

    logic       window;
    logic       wrap;
    logic       owner_val;
    logic       issue;
    logic       capture;
    logic [1:0] drain;
    logic [1:0] fill;

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        window     = (cnt == '0);
        wrap       = (cnt == c_cnt_last);
        owner_val  = slot_owner ? req1.val : req0.val;
        issue      = 1'b0;
        capture    = 1'b0;
        state_next = state;
        case (state)
            ST_IDLE: begin
                issue = window && owner_val && mem_req.rdy && !full[slot_owner];
                if (issue) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                capture = mem_resp.val;
                if (mem_resp.val) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        drain = full & {resp1.rdy, resp0.rdy};
        fill  = capture ? (pend_dom ? 2'b10 : 2'b01) : 2'b00;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            slot_owner <= 1'b0;
            pend_dom   <= 1'b0;
            full       <= 2'b00;
            overrun    <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= wrap ? '0 : cnt + 1'b1;
            if (wrap) begin
                slot_owner <= ~slot_owner;
            end
            if (issue) begin
                pend_dom <= slot_owner;
            end
            // A slot boundary crossed while waiting means memory broke the latency contract.
            if (wrap && state == ST_WAIT) begin
                overrun <= 1'b1;
            end
            full <= (full & ~drain) | fill;
        end
    end

    // NOTE: buffer payload is left unreset; the full bits alone decide whether it is visible.
    always_ff @(posedge clk) begin
        if (capture) begin
            buf_ctl[pend_dom]  <= mem_resp.control;
            buf_data[pend_dom] <= mem_resp.data;
        end
    end

    assign req0.rdy        = issue && !slot_owner;
    assign req1.rdy        = issue && slot_owner;

    assign mem_req.val     = (state == ST_IDLE) && window && owner_val && !full[slot_owner];
    assign mem_req.control = slot_owner ? req1.control : req0.control;
    assign mem_req.data    = slot_owner ? req1.data : req0.data;
    assign mem_req_domain  = slot_owner;

    assign mem_resp.rdy    = 1'b1;

    assign resp0.val       = full[0];
    assign resp0.control   = buf_ctl[0];
    assign resp0.data      = buf_data[0];
    assign resp1.val       = full[1];
    assign resp1.control   = buf_ctl[1];
    assign resp1.data      = buf_data[1];

endmodule

// File: tb/tb_plab5_mcore_mem_tdm_arb.sv
// Bench for the TDM memory arbiter: directed slot-schedule scenarios plus a randomized run
// against a slot-arithmetic reference model, with a behavioural memory of adjustable latency.
module tb_plab5_mcore_mem_tdm_arb;
    localparam int c_slot        = 8;
    localparam int c_req_cnbits  = 47;
    localparam int c_resp_cnbits = 15;
    localparam int c_data_nbits  = 128;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic mem_req_domain;
    logic slot_owner;
    logic overrun;

    plab5_mcore_mem_tdm_arb_if #(.p_ctrl_nbits(c_req_cnbits),  .p_data_nbits(c_data_nbits)) req0 ();
    plab5_mcore_mem_tdm_arb_if #(.p_ctrl_nbits(c_req_cnbits),  .p_data_nbits(c_data_nbits)) req1 ();
    plab5_mcore_mem_tdm_arb_if #(.p_ctrl_nbits(c_req_cnbits),  .p_data_nbits(c_data_nbits)) mem_req ();
    plab5_mcore_mem_tdm_arb_if #(.p_ctrl_nbits(c_resp_cnbits), .p_data_nbits(c_data_nbits)) resp0 ();
    plab5_mcore_mem_tdm_arb_if #(.p_ctrl_nbits(c_resp_cnbits), .p_data_nbits(c_data_nbits)) resp1 ();
    plab5_mcore_mem_tdm_arb_if #(.p_ctrl_nbits(c_resp_cnbits), .p_data_nbits(c_data_nbits)) mem_resp ();

    plab5_mcore_mem_tdm_arb #(
        .p_data_nbits  (c_data_nbits),
        .p_req_cnbits  (c_req_cnbits),
        .p_resp_cnbits (c_resp_cnbits),
        .p_slot_cycles (c_slot)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req0           (req0),
        .req1           (req1),
        .resp0          (resp0),
        .resp1          (resp1),
        .mem_req        (mem_req),
        .mem_req_domain (mem_req_domain),
        .mem_resp       (mem_resp),
        .slot_owner     (slot_owner),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    int   checks    = 0;
    int   errors    = 0;
    logic rst_level = 1'b0;
    int   lat       = 1;

    // Behavioural memory: a request accepted in cycle c is answered during cycle c+lat.
    int                         cyc     = 0;
    logic                       acc     = 1'b0;
    logic                       mr_pend = 1'b0;
    int                         mr_due  = 0;
    logic [c_resp_cnbits-1:0]   mr_ctl  = '0;
    logic [c_data_nbits-1:0]    mr_data = '0;

    always @(negedge clk) acc <= mem_req.val && mem_req.rdy;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mr_pend && cyc == mr_due) mr_pend <= 1'b0;
        if (acc === 1'b1) begin
            mr_pend <= 1'b1;
            mr_due  <= cyc + lat;
            mr_ctl  <= 15'($urandom);
            mr_data <= {$urandom, $urandom, $urandom, $urandom};
        end
    end

    assign mem_resp.val     = mr_pend && (cyc == mr_due);
    assign mem_resp.control = mr_ctl;
    assign mem_resp.data    = mr_data;

    // One clock cycle: inputs change just after the rising edge, outputs are sampled at the falling edge.
    task automatic drive_cycle(input logic v0, input logic v1, input logic r0, input logic r1, input logic mr);
        @(posedge clk);
        #1;
        reset         = rst_level;
        req0.val      = v0;
        req1.val      = v1;
        resp0.rdy     = r0;
        resp1.rdy     = r1;
        mem_req.rdy   = mr;
        req0.control  = 47'({$urandom, $urandom});
        req1.control  = 47'({$urandom, $urandom});
        req0.data     = {$urandom, $urandom, $urandom, $urandom};
        req1.data     = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
    endtask

    // Three cycles of reset; the next drive_cycle call is cycle 0 of the schedule.
    task automatic do_reset();
        rst_level = 1'b0;
        repeat (3) drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        rst_level = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            if (c == 0) begin
                checks++; if (req0.rdy !== 1'b0) begin errors++; $display("FAIL rst_req0_rdy got %b want 0", req0.rdy); end
                checks++; if (req1.rdy !== 1'b0) begin errors++; $display("FAIL rst_req1_rdy got %b want 0", req1.rdy); end
                checks++; if (mem_req.val !== 1'b0) begin errors++; $display("FAIL rst_mem_req_val got %b want 0", mem_req.val); end
                checks++; if (resp0.val !== 1'b0) begin errors++; $display("FAIL rst_resp0_val got %b want 0", resp0.val); end
                checks++; if (resp1.val !== 1'b0) begin errors++; $display("FAIL rst_resp1_val got %b want 0", resp1.val); end
                checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got %b want 0", overrun); end
                checks++; if (mem_resp.rdy !== 1'b1) begin errors++; $display("FAIL rst_mem_resp_rdy got %b want 1", mem_resp.rdy); end
            end
            checks++;
            if (slot_owner !== (c >= c_slot)) begin
                errors++; $display("FAIL rst_slot_owner cycle %0d got %b want %b", c, slot_owner, (c >= c_slot));
            end
        end
    endtask

    task automatic test_late_req();
        int                       grant_at = -1;
        int                       resp_at  = -1;
        logic                     v0       = 1'b0;
        logic [c_resp_cnbits-1:0] exp_ctl  = 'x;
        logic [c_data_nbits-1:0]  exp_data = 'x;
        lat = 1;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            if (c == 3) v0 = 1'b1;
            drive_cycle(v0, 1'b0, 1'b1, 1'b1, 1'b1);
            if (req0.rdy === 1'b1 && grant_at < 0) begin
                grant_at = c;
                v0 = 1'b0;
                checks++; if (mem_req_domain !== 1'b0) begin errors++; $display("FAIL late_domain got %b want 0", mem_req_domain); end
                checks++; if (mem_req.data !== req0.data) begin errors++; $display("FAIL late_req_data got %h want %h", mem_req.data, req0.data); end
            end
            if (mem_resp.val) begin
                exp_ctl  = mem_resp.control;
                exp_data = mem_resp.data;
            end
            if (resp0.val === 1'b1 && resp_at < 0) begin
                resp_at = c;
                checks++; if (resp0.data !== exp_data) begin errors++; $display("FAIL late_resp_data got %h want %h", resp0.data, exp_data); end
                checks++; if (resp0.control !== exp_ctl) begin errors++; $display("FAIL late_resp_ctl got %h want %h", resp0.control, exp_ctl); end
            end
            checks++; if (resp1.val !== 1'b0) begin errors++; $display("FAIL late_resp1_val cycle %0d got %b want 0", c, resp1.val); end
        end
        checks++; if (grant_at != 16) begin errors++; $display("FAIL late_grant_cycle got %0d want 16", grant_at); end
        checks++; if (resp_at != 18) begin errors++; $display("FAIL late_resp_cycle got %0d want 18", resp_at); end
    endtask

    // Shared body for the two-domain saturation scenarios; r0 controls domain-0 backpressure.
    task automatic test_saturate(input logic r0);
        int exp_cyc [4];
        int exp_dom [4];
        int n_exp;
        int n = 0;
        string tag;
        tag = r0 ? "sat" : "bp";
        if (r0) begin
            exp_cyc = '{0, 8, 16, 24}; exp_dom = '{0, 1, 0, 1}; n_exp = 4;
        end else begin
            exp_cyc = '{0, 8, 24, 0};  exp_dom = '{0, 1, 1, 0}; n_exp = 3;
        end
        lat = 1;
        do_reset();
        for (int c = 0; c < 32; c++) begin
            logic exp_r0;
            logic exp_r1;
            drive_cycle(1'b1, 1'b1, r0, 1'b1, 1'b1);
            if (mem_req.val === 1'b1 && mem_req.rdy === 1'b1) begin
                checks++;
                if (n >= n_exp || c != exp_cyc[n] || mem_req_domain !== exp_dom[n][0]) begin
                    errors++; $display("FAIL %s_grant got cycle %0d dom %b want grant #%0d of %0d", tag, c, mem_req_domain, n, n_exp);
                end
                n++;
            end
            exp_r0 = r0 ? (c == 2 || c == 18) : (c >= 2);
            exp_r1 = (c == 10 || c == 26);
            checks++; if (resp0.val !== exp_r0) begin errors++; $display("FAIL %s_resp0_val cycle %0d got %b want %b", tag, c, resp0.val, exp_r0); end
            checks++; if (resp1.val !== exp_r1) begin errors++; $display("FAIL %s_resp1_val cycle %0d got %b want %b", tag, c, resp1.val, exp_r1); end
            if (c == 16) begin
                checks++; if (req0.rdy !== r0) begin errors++; $display("FAIL %s_req0_rdy_16 got %b want %b", tag, req0.rdy, r0); end
            end
        end
        checks++; if (n != n_exp) begin errors++; $display("FAIL %s_grant_count got %0d want %0d", tag, n, n_exp); end
    endtask

    task automatic test_slow_mem();
        int                      n_grant  = 0;
        logic                    v0       = 1'b1;
        logic [c_data_nbits-1:0] exp_data = 'x;
        lat = 10;
        do_reset();
        for (int c = 0; c < 32; c++) begin
            drive_cycle(v0, 1'b0, 1'b1, 1'b1, 1'b1);
            if (mem_req.val === 1'b1 && mem_req.rdy === 1'b1) begin
                n_grant++;
                v0 = 1'b0;
                checks++; if (c != 0) begin errors++; $display("FAIL slow_grant_cycle got %0d want 0", c); end
            end
            if (mem_resp.val) exp_data = mem_resp.data;
            checks++; if (overrun !== (c >= 8)) begin errors++; $display("FAIL slow_overrun cycle %0d got %b want %b", c, overrun, (c >= 8)); end
            checks++; if (resp0.val !== (c == 11)) begin errors++; $display("FAIL slow_resp0_val cycle %0d got %b want %b", c, resp0.val, (c == 11)); end
            if (c == 11) begin
                checks++; if (resp0.data !== exp_data) begin errors++; $display("FAIL slow_resp_data got %h want %h", resp0.data, exp_data); end
            end
            checks++; if (resp1.val !== 1'b0) begin errors++; $display("FAIL slow_resp1_val cycle %0d got %b want 0", c, resp1.val); end
        end
        checks++; if (n_grant != 1) begin errors++; $display("FAIL slow_grant_count got %0d want 1", n_grant); end
        lat = 1;
        do_reset();
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL slow_overrun_cleared got %b want 0", overrun); end
    endtask

    task automatic test_reset_in_wait();
        int                      n_grant  = 0;
        logic                    v0       = 1'b0;
        logic [c_data_nbits-1:0] exp_data = 'x;
        lat = 5;
        do_reset();
        for (int c = 0; c < 18; c++) begin
            rst_level = !(c >= 2 && c <= 5);
            if (c == 0 || c == 6) v0 = 1'b1;
            drive_cycle(v0, 1'b0, 1'b1, 1'b1, 1'b1);
            if (reset === 1'b1 && mem_req.val === 1'b1 && mem_req.rdy === 1'b1) begin
                checks++;
                if (!((n_grant == 0 && c == 0) || (n_grant == 1 && c == 6))) begin
                    errors++; $display("FAIL rw_grant got cycle %0d (grant #%0d) want cycles 0 and 6", c, n_grant);
                end
                n_grant++;
                v0 = 1'b0;
            end
            if (mem_resp.val) exp_data = mem_resp.data;
            checks++; if (resp0.val !== (c == 12)) begin errors++; $display("FAIL rw_resp0_val cycle %0d got %b want %b", c, resp0.val, (c == 12)); end
            if (c == 12) begin
                checks++; if (resp0.data !== exp_data) begin errors++; $display("FAIL rw_resp_data got %h want %h", resp0.data, exp_data); end
            end
        end
        rst_level = 1'b1;
        checks++; if (n_grant != 2) begin errors++; $display("FAIL rw_grant_count got %0d want 2", n_grant); end
    endtask

    // Reference model: slot number = cycle / c_slot, owner = slot parity, issue only at slot start.
    task automatic test_random();
        int                       m_t      = 0;
        logic                     m_busy   = 1'b0;
        logic                     m_dom    = 1'b0;
        logic                     m_over   = 1'b0;
        logic [1:0]               m_full   = 2'b00;
        logic [c_resp_cnbits-1:0] m_ctl  [2];
        logic [c_data_nbits-1:0]  m_data [2];
        lat = 1;
        do_reset();
        for (int c = 0; c < 640; c++) begin
            logic       v0, v1, r0, r1, mr, owner, window, e_mval, e_grant;
            logic [1:0] nxt_full;
            v0  = ($urandom_range(0, 9) < 7);
            v1  = ($urandom_range(0, 9) < 7);
            r0  = $urandom_range(0, 1);
            r1  = $urandom_range(0, 1);
            mr  = ($urandom_range(0, 9) < 8);
            lat = $urandom_range(1, c_slot - 2);
            drive_cycle(v0, v1, r0, r1, mr);

            owner   = 1'((m_t / c_slot) % 2);
            window  = (m_t % c_slot) == 0;
            e_mval  = window && !m_busy && (owner ? v1 : v0) && !m_full[owner];
            e_grant = e_mval && mr;

            checks++; if (slot_owner !== owner) begin errors++; $display("FAIL rnd_slot_owner cycle %0d got %b want %b", c, slot_owner, owner); end
            checks++; if (mem_req_domain !== owner) begin errors++; $display("FAIL rnd_domain cycle %0d got %b want %b", c, mem_req_domain, owner); end
            checks++; if (mem_req.val !== e_mval) begin errors++; $display("FAIL rnd_mem_req_val cycle %0d got %b want %b", c, mem_req.val, e_mval); end
            checks++; if (req0.rdy !== (e_grant && !owner)) begin errors++; $display("FAIL rnd_req0_rdy cycle %0d got %b want %b", c, req0.rdy, e_grant && !owner); end
            checks++; if (req1.rdy !== (e_grant && owner)) begin errors++; $display("FAIL rnd_req1_rdy cycle %0d got %b want %b", c, req1.rdy, e_grant && owner); end
            checks++; if (resp0.val !== m_full[0]) begin errors++; $display("FAIL rnd_resp0_val cycle %0d got %b want %b", c, resp0.val, m_full[0]); end
            checks++; if (resp1.val !== m_full[1]) begin errors++; $display("FAIL rnd_resp1_val cycle %0d got %b want %b", c, resp1.val, m_full[1]); end
            checks++; if (overrun !== m_over) begin errors++; $display("FAIL rnd_overrun cycle %0d got %b want %b", c, overrun, m_over); end
            if (e_mval) begin
                checks++;
                if (mem_req.data !== (owner ? req1.data : req0.data) || mem_req.control !== (owner ? req1.control : req0.control)) begin
                    errors++; $display("FAIL rnd_mem_req_payload cycle %0d got %h want %h", c, mem_req.data, owner ? req1.data : req0.data);
                end
            end
            if (m_full[0]) begin
                checks++;
                if (resp0.data !== m_data[0] || resp0.control !== m_ctl[0]) begin
                    errors++; $display("FAIL rnd_resp0_payload cycle %0d got %h want %h", c, resp0.data, m_data[0]);
                end
            end
            if (m_full[1]) begin
                checks++;
                if (resp1.data !== m_data[1] || resp1.control !== m_ctl[1]) begin
                    errors++; $display("FAIL rnd_resp1_payload cycle %0d got %h want %h", c, resp1.data, m_data[1]);
                end
            end

            nxt_full = m_full & ~{m_full[1] && r1, m_full[0] && r0};
            if (m_busy && mem_resp.val) begin
                nxt_full[m_dom] = 1'b1;
                m_ctl[m_dom]    = mem_resp.control;
                m_data[m_dom]   = mem_resp.data;
            end
            if (m_busy && (m_t % c_slot) == c_slot - 1) m_over = 1'b1;
            m_busy = (m_busy && !mem_resp.val) || e_grant;
            if (e_grant) m_dom = owner;
            m_full = nxt_full;
            m_t++;
        end
    endtask

    initial begin
        req0.val = 1'b0; req1.val = 1'b0; req0.control = '0; req1.control = '0;
        req0.data = '0; req1.data = '0;
        resp0.rdy = 1'b1; resp1.rdy = 1'b1; mem_req.rdy = 1'b1;
        test_reset();
        test_late_req();
        test_saturate(1'b1);
        test_saturate(1'b0);
        test_slow_mem();
        test_reset_in_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
